// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter: FSM states,
// record-terminator bytes and the clock-to-baud divider helper.
package fifo_uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_LOAD  = 3'd2,
      S_START = 3'd3,
      S_DATA  = 3'd4,
      S_STOP  = 3'd5
   } state_t;

   localparam logic [7:0] LF = 8'h0A;
   localparam logic [7:0] CR = 8'h0D;

   // Integer truncation; no fractional-baud correction is attempted.
   function automatic int calc_baud_div(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: emits a one-cycle tick on the last clock of every
// BAUD_DIV-clock bit period; clear restarts the period from zero.
module uart_baud_cnt #(
   parameter int BAUD_DIV = 434
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   output logic tick
);

   localparam logic [15:0] LAST = 16'(BAUD_DIV - 1);

   logic [15:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 16'd1;
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the show-ahead-off sample FIFO and sends each one as an
// 8-bit, no-parity UART frame; pulses line_done when a record-ending LF leaves.
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD      = 115200,
   parameter int BAUD_DIV  = calc_baud_div(CLK_FREQ, BAUD),
   parameter int STOP_BITS = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        tx_en,
   input  logic        fifo_empty,
   input  logic [7:0]  fifo_q,
   output logic        fifo_rdreq,
   output logic        uart_txd,
   output logic        busy,
   output logic        line_done,
   output logic [15:0] byte_cnt
);

   localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

   state_t      state, state_nx;
   logic        tick, clear, stop_last;
   logic        txd_q, line_done_q;
   logic [7:0]  shift_q;
   logic [2:0]  bit_cnt;
   logic [15:0] byte_cnt_q;

   assign stop_last = (bit_cnt == STOP_LAST);
   assign clear     = (state_nx != state);

   uart_baud_cnt #(.BAUD_DIV(BAUD_DIV)) u_baud (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear),
      .tick    (tick)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (tx_en && !fifo_empty) state_nx = S_READ;
         S_READ:  state_nx = S_LOAD;
         S_LOAD:  state_nx = S_START;
         S_START: if (tick) state_nx = S_DATA;
         S_DATA:  if (tick && bit_cnt == 3'd7) state_nx = S_STOP;
         S_STOP:  if (tick && stop_last) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      fifo_rdreq = (state == S_READ);
      busy       = (state != S_IDLE);
   end

   // The shift register rotates rather than shifts, so after the eighth
   // rotation it holds the original byte again for the LF compare at stop end.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         txd_q       <= 1'b1;
         shift_q     <= '0;
         bit_cnt     <= '0;
         byte_cnt_q  <= '0;
         line_done_q <= 1'b0;
      end else begin
         line_done_q <= 1'b0;
         case (state)
            S_LOAD: begin
               shift_q <= fifo_q;
               txd_q   <= 1'b0;
               bit_cnt <= '0;
            end
            S_START: begin
               if (tick) begin
                  txd_q   <= shift_q[0];
                  shift_q <= {shift_q[0], shift_q[7:1]};
               end
            end
            S_DATA: begin
               if (tick) begin
                  if (bit_cnt == 3'd7) begin
                     txd_q   <= 1'b1;
                     bit_cnt <= '0;
                  end else begin
                     txd_q   <= shift_q[0];
                     shift_q <= {shift_q[0], shift_q[7:1]};
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end
            end
            S_STOP: begin
               if (tick) begin
                  if (stop_last) begin
                     byte_cnt_q  <= byte_cnt_q + 16'd1;
                     line_done_q <= (shift_q == LF);
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign uart_txd  = txd_q;
   assign line_done = line_done_q;
   assign byte_cnt  = byte_cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a FIFO model feeds three parameterisations of the
// transmitter; a line decoder pops the expected-byte queue as frames complete.
module tb_fifo_uart_tx;
   import fifo_uart_pkg::*;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, tx_en;
   logic [1:0]  sel;
   logic [7:0]  fifo_q;
   logic [7:0]  mem [256];
   logic [7:0]  push_cnt, pop_cnt;
   logic        fifo_empty;
   logic [2:0]  txd_v, rdreq_v, busy_v, ld_v;
   logic [15:0] bc_v [3];
   logic        txd, rdreq, busy, ld;
   logic [15:0] bcnt;
   int          cur_bd, cur_sb;

   int n_chk, n_fail;
   int pos, hi_run, frames_done, ld_count, rdreq_cnt;
   bit in_frame, gap_armed;
   int gq[$];
   logic [7:0] exp_q[$];

   assign fifo_empty = (push_cnt == pop_cnt);
   assign txd    = txd_v[sel];
   assign rdreq  = rdreq_v[sel];
   assign busy   = busy_v[sel];
   assign ld     = ld_v[sel];
   assign bcnt   = bc_v[sel];
   assign cur_bd = (sel == 2'd2) ? 434 : 4;
   assign cur_sb = (sel == 2'd1) ? 2 : 1;

   fifo_uart_tx #(.BAUD_DIV(4), .STOP_BITS(1)) u_a (
      .clk(clk), .reset_n(reset_n), .tx_en(tx_en && sel == 2'd0),
      .fifo_empty(fifo_empty || sel != 2'd0), .fifo_q(fifo_q),
      .fifo_rdreq(rdreq_v[0]), .uart_txd(txd_v[0]), .busy(busy_v[0]),
      .line_done(ld_v[0]), .byte_cnt(bc_v[0])
   );

   fifo_uart_tx #(.BAUD_DIV(4), .STOP_BITS(2)) u_b (
      .clk(clk), .reset_n(reset_n), .tx_en(tx_en && sel == 2'd1),
      .fifo_empty(fifo_empty || sel != 2'd1), .fifo_q(fifo_q),
      .fifo_rdreq(rdreq_v[1]), .uart_txd(txd_v[1]), .busy(busy_v[1]),
      .line_done(ld_v[1]), .byte_cnt(bc_v[1])
   );

   fifo_uart_tx #(.STOP_BITS(1)) u_c (
      .clk(clk), .reset_n(reset_n), .tx_en(tx_en && sel == 2'd2),
      .fifo_empty(fifo_empty || sel != 2'd2), .fifo_q(fifo_q),
      .fifo_rdreq(rdreq_v[2]), .uart_txd(txd_v[2]), .busy(busy_v[2]),
      .line_done(ld_v[2]), .byte_cnt(bc_v[2])
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_byte(input logic [7:0] b, input bit will_send);
      mem[push_cnt] = b;
      push_cnt = push_cnt + 8'd1;
      if (will_send) exp_q.push_back(b);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic wait_frames(input int target, input int budget);
      int n = 0;
      while (frames_done < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_eq("frame_timeout", frames_done >= target, 1'b1);
   endtask

   task automatic wait_pos(input int p, input int budget);
      int n = 0;
      while (!(in_frame && pos >= p) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_eq("pos_timeout", in_frame && pos >= p, 1'b1);
   endtask

   // FIFO with show-ahead off: data appears the cycle after the read request.
   initial begin
      logic pend;
      pop_cnt = '0;
      fifo_q  = '0;
      forever begin
         @(negedge clk);
         pend = rdreq;
         if (pend) check_eq("no_underflow", fifo_empty, 1'b0);
         @(posedge clk);
         if (pend) begin
            fifo_q  <= mem[pop_cnt];
            pop_cnt <= pop_cnt + 8'd1;
         end
      end
   end

   // Line decoder: one sample per clock; a frame closes on the first sample
   // after the last stop clock, where the DUT must already be idle.
   initial begin
      logic       lvl [11];
      logic [7:0] got, want;
      bit         glitch, stop_ok;
      int         nb;
      in_frame = 0; gap_armed = 0; hi_run = 0; pos = 0;
      frames_done = 0; ld_count = 0; rdreq_cnt = 0; glitch = 0;
      forever begin
         @(negedge clk);
         nb = 9 + cur_sb;
         if (ld) ld_count++;
         if (rdreq) rdreq_cnt++;
         if (!reset_n) begin
            in_frame = 0; gap_armed = 0; hi_run = 0;
         end else begin
            if (!in_frame) begin
               if (txd == 1'b0) begin
                  if (gap_armed) gq.push_back(hi_run);
                  in_frame = 1; pos = 0; glitch = 0;
               end else begin
                  hi_run++;
               end
            end
            if (in_frame) begin
               if (pos < nb * cur_bd) begin
                  if (pos % cur_bd == 0) lvl[pos / cur_bd] = txd;
                  else if (txd !== lvl[pos / cur_bd]) glitch = 1;
                  if (pos == nb * cur_bd - 1) check_eq("busy_last_stop", busy, 1'b1);
                  pos++;
               end else begin
                  for (int i = 0; i < 8; i++) got[i] = lvl[i + 1];
                  stop_ok = 1;
                  for (int i = 9; i < nb; i++) if (lvl[i] !== 1'b1) stop_ok = 0;
                  check_eq("start_bit", lvl[0], 1'b0);
                  check_eq("stop_bits", stop_ok, 1'b1);
                  check_eq("bit_hold", glitch, 1'b0);
                  check_eq("frame_len", busy, 1'b0);
                  check_eq("sb_depth", exp_q.size() > 0, 1'b1);
                  if (exp_q.size() > 0) begin
                     want = exp_q.pop_front();
                     check_eq("frame_data", got, want);
                     check_eq("line_done", ld, want == LF);
                  end
                  in_frame = 0; hi_run = 1; gap_armed = 1;
                  frames_done++;
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached after %0d frames", frames_done);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base_rd, base_ld;
      n_chk = 0; n_fail = 0;
      push_cnt = '0; reset_n = 1'b0; tx_en = 1'b0; sel = 2'd0;

      repeat (2) @(negedge clk);
      check_eq("rst_txd", txd, 1'b1);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_rdreq", rdreq, 1'b0);
      check_eq("rst_line_done", ld, 1'b0);
      check_eq("rst_byte_cnt", bcnt, 16'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Single 0xA5 frame, held off by tx_en first.
      push_byte(8'hA5, 1);
      base_rd = rdreq_cnt; base_ld = ld_count;
      repeat (10) @(negedge clk);
      check_eq("gated_rdreq", rdreq_cnt - base_rd, 0);
      check_eq("gated_txd", txd, 1'b1);
      tx_en = 1'b1;
      @(negedge clk); check_eq("rdreq_latency", rdreq, 1'b1);
      @(negedge clk); check_eq("txd_pre_fall", txd, 1'b1);
      @(negedge clk); check_eq("txd_fall", txd, 1'b0);
      wait_frames(frames_done + 1, 100);
      check_eq("a5_byte_cnt", bcnt, 16'd1);
      check_eq("a5_rdreq", rdreq_cnt - base_rd, 1);
      check_eq("a5_line_done", ld_count - base_ld, 0);

      // Record tail CR LF after a data byte, back to back.
      do_reset();
      gq.delete();
      tx_en = 1'b0;
      push_byte(8'h31, 1); push_byte(CR, 1); push_byte(LF, 1);
      base_ld = ld_count;
      tx_en = 1'b1;
      wait_frames(frames_done + 3, 300);
      check_eq("rec_byte_cnt", bcnt, 16'd3);
      check_eq("rec_line_done", ld_count - base_ld, 1);
      check_eq("rec_gap_count", gq.size(), 2);
      if (gq.size() == 2) begin
         check_eq("rec_gap0", gq[0], 3);
         check_eq("rec_gap1", gq[1], 3);
      end

      // tx_en dropped mid-frame: frame finishes, next byte stays queued.
      base_rd = rdreq_cnt;
      push_byte(8'h3C, 1); push_byte(8'h99, 0);
      wait_pos(8, 50);
      tx_en = 1'b0;
      wait_frames(frames_done + 1, 100);
      repeat (20) @(negedge clk);
      check_eq("txen_rdreq", rdreq_cnt - base_rd, 1);
      check_eq("txen_fifo_left", push_cnt - pop_cnt, 8'd1);
      check_eq("txen_txd_idle", txd, 1'b1);
      check_eq("txen_busy", busy, 1'b0);
      check_eq("txen_byte_cnt", bcnt, 16'd4);

      // Reset during bit3 of 0x99 aborts it; 0x7E then goes out cleanly.
      push_byte(8'h7E, 1);
      tx_en = 1'b1;
      wait_pos(4 * cur_bd + 1, 60);
      reset_n = 1'b0;
      @(negedge clk);
      check_eq("abort_txd", txd, 1'b1);
      check_eq("abort_busy", busy, 1'b0);
      check_eq("abort_byte_cnt", bcnt, 16'd0);
      check_eq("abort_rdreq", rdreq, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      wait_frames(frames_done + 1, 200);
      check_eq("abort_resume_cnt", bcnt, 16'd1);
      check_eq("abort_fifo_left", push_cnt - pop_cnt, 8'd0);

      // Two stop bits, two queued bytes.
      tx_en = 1'b0;
      sel = 2'd1;
      do_reset();
      gq.delete();
      push_byte(8'hF0, 1); push_byte(8'h0F, 1);
      tx_en = 1'b1;
      wait_frames(frames_done + 2, 200);
      check_eq("sb2_byte_cnt", bcnt, 16'd2);
      check_eq("sb2_gap_count", gq.size(), 1);
      if (gq.size() == 1) check_eq("sb2_gap", gq[0], 3);

      // Default divider from 50 MHz / 115200.
      tx_en = 1'b0;
      sel = 2'd2;
      do_reset();
      push_byte(8'h55, 1);
      tx_en = 1'b1;
      wait_frames(frames_done + 1, 6000);
      check_eq("def_byte_cnt", bcnt, 16'd1);
      check_eq("def_sb_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
